// File: rtl/lifo_reader.sv
`default_nettype none
// ============================================================================
//  Module   : lifo_reader
//  Purpose  : Read-side controller for the lifo stack. Pops a commanded number
//             of words through the LIFO read port and presents them on a
//             valid/ready stream, with last_o marking the final word.
//             The LIFO's registered read data is treated as one extra buffer
//             slot, so valid_o can assert directly from lifo_q_i. Together
//             with the 2-entry skid buffer, this sustains 1 word/cycle and
//             never loses a word under backpressure.
//  Ports    : clk_i, arst_n_i         clock, asynchronous active-low reset
//             start_i, len_i          command strobe and word count (IDLE only)
//             busy_o, done_o, err_o   status; done_o and err_o are 1-cycle pulses
//             lifo_rdreq_o, lifo_q_i, lifo_empty_i, lifo_usedw_i
//                                     LIFO read port (1-cycle read latency)
//             data_o, valid_o, ready_i, last_o
//                                     output stream
//  Options  : define LIFO_READER_TIMEOUT_EN to abort a transfer after
//             TIMEOUT_CYCLES consecutive empty-stall cycles.
//  Revision : 1.0  initial release
// ============================================================================
module lifo_reader #(
    parameter int DWIDTH         = 16,
    parameter int AWIDTH         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              start_i,
    input  logic [AWIDTH:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              lifo_rdreq_o,
    input  logic [DWIDTH-1:0] lifo_q_i,
    input  logic              lifo_empty_i,
    input  logic [AWIDTH:0]   lifo_usedw_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              last_o
);

    localparam logic [AWIDTH:0] c_ZERO = '0;
    localparam logic [AWIDTH:0] c_ONE  = {{AWIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [AWIDTH:0]   r_req_cnt;
    logic [AWIDTH:0]   r_out_cnt;
    logic              r_inflight;
    logic [DWIDTH-1:0] r_buf0;
    logic [DWIDTH-1:0] r_buf1;
    logic [1:0]        r_buf_count;
    logic              r_done;
    logic              r_err;

    logic              w_valid;
    logic [DWIDTH-1:0] w_head;
    logic              w_accept;
    logic              w_accept_last;
    logic [1:0]        w_occ;
    logic              w_rdreq;
    logic              w_start_ok;
    logic              w_start_zero;
    logic              w_start_rej;
    logic              w_done_set;
    logic              w_err_set;
    logic              w_timeout;
    logic              w_abort;

    // ------------------------------------------------------------------
    // Stream side. A word sitting in the LIFO output register (inflight)
    // is presented directly when the skid buffer is empty.
    // ------------------------------------------------------------------
    assign w_valid  = (r_buf_count != 2'd0) | r_inflight;
    assign w_head   = (r_buf_count != 2'd0) ? r_buf0 : lifo_q_i;
    assign w_accept = w_valid & ready_i;
    // After an abort out_cnt never reaches 1 while words remain, so last_o
    // stays low on the partial drain without any extra gating.
    assign w_accept_last = w_accept & (r_out_cnt == c_ONE) & (r_state != ST_IDLE);

    // Occupancy counts the inflight word, so at most two words are ever owed.
    assign w_occ   = r_buf_count + {1'b0, r_inflight};
    assign w_rdreq = (r_state == ST_READ) & (r_req_cnt != c_ZERO) &
                     !lifo_empty_i & (w_occ < 2'd2);

    assign w_start_zero = (r_state == ST_IDLE) & start_i & (len_i == c_ZERO);
    assign w_start_rej  = (r_state == ST_IDLE) & start_i & (len_i != c_ZERO) &
                          (len_i > lifo_usedw_i);
    assign w_start_ok   = (r_state == ST_IDLE) & start_i & (len_i != c_ZERO) &
                          (len_i <= lifo_usedw_i);

`ifdef LIFO_READER_TIMEOUT_EN
    localparam int c_TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_abort;
    logic              w_stall;

    assign w_stall   = (r_state == ST_READ) & (r_req_cnt != c_ZERO) & lifo_empty_i;
    assign w_timeout = w_stall & (r_to_cnt == c_TO_LAST);
    assign w_abort   = r_abort;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_to_cnt <= '0;
            r_abort  <= 1'b0;
        end else begin
            if ((r_state != ST_READ) || w_rdreq || w_timeout) begin
                r_to_cnt <= '0;
            end else if (w_stall) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_abort <= 1'b1;
            end else if (w_state_nxt == ST_IDLE) begin
                r_abort <= 1'b0;
            end
        end
    end
`else
    // Timeout disabled: READ waits indefinitely on an empty LIFO. The
    // comparison is always false and only keeps the parameter referenced.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
    assign w_abort   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM next state and status pulses
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_done_set  = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_zero) begin
                    w_done_set = 1'b1;
                end else if (w_start_rej) begin
                    w_err_set = 1'b1;
                end else if (w_start_ok) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (w_timeout) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end else if (w_rdreq && (r_req_cnt == c_ONE)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Aborted transfer ends once every owed word has left.
                if (w_abort && !w_valid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_accept_last) begin
            w_done_set  = 1'b1;
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_set;
            r_err   <= w_err_set;
        end
    end

    // ------------------------------------------------------------------
    // Counters and skid buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_req_cnt   <= '0;
            r_out_cnt   <= '0;
            r_inflight  <= 1'b0;
            r_buf0      <= '0;
            r_buf1      <= '0;
            r_buf_count <= 2'd0;
        end else begin
            if (w_start_ok) begin
                r_req_cnt <= len_i;
            end else if (w_timeout) begin
                r_req_cnt <= '0;
            end else if (w_rdreq) begin
                r_req_cnt <= r_req_cnt - 1'b1;
            end

            if (w_start_ok) begin
                r_out_cnt <= len_i;
            end else if (w_accept) begin
                r_out_cnt <= r_out_cnt - 1'b1;
            end

            r_inflight <= w_rdreq;

            if (w_accept && (r_buf_count != 2'd0)) begin
                // Head leaves the buffer; an arriving word joins at the tail.
                if (r_inflight) begin
                    if (r_buf_count == 2'd1) begin
                        r_buf0 <= lifo_q_i;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= lifo_q_i;
                    end
                end else begin
                    r_buf0      <= r_buf1;
                    r_buf_count <= r_buf_count - 2'd1;
                end
            end else if (!w_accept && r_inflight) begin
                // Arriving word not taken this cycle: capture it.
                if (r_buf_count == 2'd0) begin
                    r_buf0 <= lifo_q_i;
                end else begin
                    r_buf1 <= lifo_q_i;
                end
                r_buf_count <= r_buf_count + 2'd1;
            end
            // Remaining case: the inflight word was consumed directly.
        end
    end

    assign busy_o       = (r_state != ST_IDLE);
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign lifo_rdreq_o = w_rdreq;
    assign valid_o      = w_valid;
    assign data_o       = w_valid ? w_head : '0;
    assign last_o       = w_valid & (r_out_cnt == c_ONE);

endmodule
`default_nettype wire

// File: tb/tb_lifo_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lifo_reader
//  Purpose  : Self-checking bench for lifo_reader with a behavioural LIFO
//             (1-cycle read latency) and a scoreboard-driven stream monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lifo_reader;

    localparam int DW = 16;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          start;
    logic [AW:0]   len;
    logic          busy, done, err, rdreq;
    logic [DW-1:0] q = '0;
    logic          empty;
    logic [AW:0]   usedw;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;
    logic          last;

    bit            fixed_ready;
    bit            rand_en;
    bit            rand_bit;

    always #5 clk = ~clk;

    assign ready = rand_en ? rand_bit : fixed_ready;

    lifo_reader #(.DWIDTH(DW), .AWIDTH(AW), .TIMEOUT_CYCLES(255)) dut (
        .clk_i        (clk),
        .arst_n_i     (arst_n),
        .start_i      (start),
        .len_i        (len),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .lifo_rdreq_o (rdreq),
        .lifo_q_i     (q),
        .lifo_empty_i (empty),
        .lifo_usedw_i (usedw),
        .data_o       (data),
        .valid_o      (valid),
        .ready_i      (ready),
        .last_o       (last)
    );

    // Behavioural LIFO
    logic [DW-1:0] mem [0:511];
    int            sp   = 0;
    int            pops = 0;
    logic          wr;
    logic [DW-1:0] wdata;

    always @(posedge clk) begin
        if (rdreq && sp > 0) begin
            q    <= mem[sp-1];
            sp   <= sp - 1;
            pops <= pops + 1;
        end else if (wr) begin
            mem[sp] <= wdata;
            sp      <= sp + 1;
        end
    end
    assign empty = (sp == 0);
    assign usedw = (AW+1)'(sp);

    always @(posedge clk) begin
        #1 rand_bit = 1'($urandom_range(0, 1));
    end

    // Scoreboard
    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;
    exp_t sbq[$];

    int tests = 0;
    int fails = 0;
    int acc_total   = 0;
    int done_pulses = 0;
    int err_pulses  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_d;
    logic          prev_l;

    always @(negedge clk) begin
        exp_t e;
        if (arst_n) begin
            if (done) done_pulses++;
            if (err)  err_pulses++;
            if (rdreq && empty) chk("pop_on_empty", 32'(empty), 32'd0);
            if (prev_stall) begin
                chk("stall_valid", 32'(valid), 32'd1);
                chk("stall_data",  32'(data),  32'(prev_d));
                chk("stall_last",  32'(last),  32'(prev_l));
            end
            if (valid && ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_word", 32'(sbq.size()), 32'd1);
                end else begin
                    e = sbq.pop_front();
                    chk("word_data", 32'(data), 32'(e.d));
                    chk("word_last", 32'(last), 32'(e.l));
                    acc_total++;
                end
            end
            prev_stall = valid && !ready;
            prev_d     = data;
            prev_l     = last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Stimulus helpers (all called at posedge+1)
    task automatic fill(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            wr    = 1'b1;
            wdata = base + DW'(i);
            @(posedge clk); #1;
        end
        wr = 1'b0;
    endtask

    task automatic start_cmd(input int n);
        start = 1'b1;
        len   = (AW+1)'(n);
        @(posedge clk); #1;
        start = 1'b0;
        len   = '0;
    endtask

    task automatic expect_from_model(input int n);
        for (int i = 0; i < n; i++)
            sbq.push_back('{d: mem[sp-1-i], l: (i == n-1)});
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_busy"},  32'(busy),  32'd0);
        chk({nm, "_done"},  32'(done),  32'd0);
        chk({nm, "_err"},   32'(err),   32'd0);
        chk({nm, "_rdreq"}, 32'(rdreq), 32'd0);
        chk({nm, "_valid"}, 32'(valid), 32'd0);
        chk({nm, "_data"},  32'(data),  32'd0);
        chk({nm, "_last"},  32'(last),  32'd0);
    endtask

    task automatic wait_done(input string nm, input int exp_k);
        int  k    = 0;
        bit  seen = 1'b0;
        while (!seen && k < 400) begin
            k++;
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk({nm, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            if (exp_k > 0) chk({nm, "_done_cycle"}, 32'(k), 32'(exp_k));
            chk({nm, "_busy_at_done"}, 32'(busy), 32'd0);
            @(negedge clk);
            chk({nm, "_done_1cyc"}, 32'(done), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int p0, a0, e0;
        arst_n      = 1'b0;
        start       = 1'b0;
        len         = '0;
        wr          = 1'b0;
        wdata       = '0;
        fixed_ready = 1'b1;
        rand_en     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        arst_n = 1'b1;
        @(posedge clk); #1;

        // Test 1: 16 words, ready=1, consecutive output from cycle 2
        fill(16, 16'h0001);
        for (int i = 0; i < 16; i++)
            sbq.push_back('{d: DW'(16 - i), l: (i == 15)});
        p0 = pops; e0 = err_pulses;
        start_cmd(16);
        @(negedge clk);
        chk("t1_rdreq_c1", 32'(rdreq), 32'd1);
        chk("t1_valid_c1", 32'(valid), 32'd0);
        @(negedge clk);
        chk("t1_valid_c2", 32'(valid), 32'd1);
        chk("t1_data_c2",  32'(data),  32'h0010);
        wait_done("t1", 16);
        chk("t1_pops",   32'(pops - p0),       32'd16);
        chk("t1_sb",     32'(sbq.size()),      32'd0);
        chk("t1_no_err", 32'(err_pulses - e0), 32'd0);

        // Test 2: same fill, random backpressure
        fill(16, 16'h0101);
        for (int i = 0; i < 16; i++)
            sbq.push_back('{d: 16'h0110 - DW'(i), l: (i == 15)});
        p0 = pops;
        rand_en = 1'b1;
        start_cmd(16);
        wait_done("t2", 0);
        rand_en = 1'b0;
        chk("t2_pops", 32'(pops - p0),  32'd16);
        chk("t2_sb",   32'(sbq.size()), 32'd0);

        // Test 3: len exceeds fill level -> rejected
        fill(4, 16'h0201);
        p0 = pops;
        start_cmd(5);
        @(negedge clk);
        chk("t3_err",   32'(err),   32'd1);
        chk("t3_busy",  32'(busy),  32'd0);
        chk("t3_rdreq", 32'(rdreq), 32'd0);
        chk("t3_done",  32'(done),  32'd0);
        @(negedge clk);
        chk("t3_err_1cyc", 32'(err),   32'd0);
        chk("t3_busy2",    32'(busy),  32'd0);
        chk("t3_rdreq2",   32'(rdreq), 32'd0);
        @(posedge clk); #1;
        chk("t3_pops", 32'(pops - p0), 32'd0);

        // Test 4: len=0 -> immediate done
        start_cmd(0);
        @(negedge clk);
        chk("t4_done",  32'(done),  32'd1);
        chk("t4_busy",  32'(busy),  32'd0);
        chk("t4_rdreq", 32'(rdreq), 32'd0);
        chk("t4_valid", 32'(valid), 32'd0);
        @(negedge clk);
        chk("t4_done_1cyc", 32'(done),  32'd0);
        chk("t4_valid2",    32'(valid), 32'd0);
        @(posedge clk); #1;
        chk("t4_pops", 32'(pops - p0), 32'd0);

        // Test 5: reset mid-transfer, then a fresh transfer
        fill(4, 16'h0301);
        chk("t5_usedw", 32'(usedw), 32'd8);
        for (int i = 0; i < 8; i++) begin
            logic [DW-1:0] v;
            v = (i < 4) ? (16'h0304 - DW'(i)) : (16'h0204 - DW'(i - 4));
            sbq.push_back('{d: v, l: (i == 7)});
        end
        a0 = acc_total;
        start_cmd(8);
        begin
            int k = 0;
            while (acc_total < a0 + 3 && k < 100) begin
                k++;
                @(negedge clk);
            end
        end
        chk("t5_three_accepted", 32'(acc_total - a0), 32'd3);
        @(posedge clk); #1;
        arst_n = 1'b0;
        #1;
        check_zero("t5_rst");
        sbq.delete();
        @(negedge clk);
        check_zero("t5_rst_hold");
        @(posedge clk); #1;
        arst_n = 1'b1;
        @(posedge clk); #1;
        fill(2, 16'h0401);
        expect_from_model(5);
        p0 = pops;
        start_cmd(5);
        wait_done("t5", 0);
        chk("t5_pops", 32'(pops - p0),  32'd5);
        chk("t5_sb",   32'(sbq.size()), 32'd0);

        chk("total_done_pulses", 32'(done_pulses), 32'd4);
        chk("total_err_pulses",  32'(err_pulses),  32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
